// File: rtl/ula_arbiter.sv
// ula_arbiter: two-port round-robin arbiter/sequencer in front of a single
// combinational ula. One operation in flight: IDLE -> EXEC -> RESP -> IDLE.
// Optional feature: define ULA_ARB_TIMEOUT_EN to drop a response that is not
// taken within TIMEOUT RESP cycles and pulse the timeout output.
module ula_arbiter #(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned OP_W    = 3,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [OP_W-1:0]   req0_op,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [OP_W-1:0]   req1_op,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_s,
    output logic [DATA_W-1:0] ula_a,
    output logic [DATA_W-1:0] ula_b,
    output logic              ula_x,
    output logic              ula_y,
    output logic              ula_z,
    input  logic [DATA_W-1:0] ula_s,
`ifdef ULA_ARB_TIMEOUT_EN
    output logic              timeout,
`endif
    output logic              busy
);

    // The 5-bit wait counter must be able to reach the limit.
    if (TIMEOUT < 1 || TIMEOUT > 31) begin : g_bad_timeout
        $error("ula_arbiter: TIMEOUT must be in 1..31");
    end

    typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

    state_e            state_q, state_d;
    logic              last_grant_q;
    logic              owner_q;
    logic [DATA_W-1:0] ula_a_q, ula_b_q, rsp_s_q;
    logic [OP_W-1:0]   ula_op_q;

    logic              grant_port;
    logic              accept;
    logic              owner_rsp_ready;

`ifdef ULA_ARB_TIMEOUT_EN
    localparam logic [4:0] WaitLast = 5'(TIMEOUT - 1);
    logic [4:0] wait_cnt_q, wait_cnt_d;
    logic       timeout_q, timeout_d;
`endif

    // Grant selection and request handshake; only meaningful in IDLE.
    always_comb begin
        grant_port = req1_valid;
        if (req0_valid && req1_valid) begin
            grant_port = ~last_grant_q;
        end
        req0_ready      = (state_q == StIdle) && req0_valid && !grant_port;
        req1_ready      = (state_q == StIdle) && req1_valid && grant_port;
        accept          = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
    end

    // Next-state logic; the non-owner's rsp_ready never matters.
    always_comb begin
        state_d = state_q;
`ifdef ULA_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        timeout_d  = 1'b0;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
`ifdef ULA_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end
            StResp: begin
                if (owner_rsp_ready) begin
                    state_d = StIdle;
`ifdef ULA_ARB_TIMEOUT_EN
                end else if (wait_cnt_q == WaitLast) begin
                    // Result is dropped; last_grant is untouched so order holds.
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 5'd1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State, operand and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            ula_a_q      <= '0;
            ula_b_q      <= '0;
            ula_op_q     <= '0;
            rsp_s_q      <= '0;
`ifdef ULA_ARB_TIMEOUT_EN
            wait_cnt_q   <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
`ifdef ULA_ARB_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
`endif
            if (accept) begin
                owner_q      <= grant_port;
                last_grant_q <= grant_port;
                ula_a_q      <= grant_port ? req1_a  : req0_a;
                ula_b_q      <= grant_port ? req1_b  : req0_b;
                ula_op_q     <= grant_port ? req1_op : req0_op;
            end
            // ula has had one full cycle to settle on the registered operands.
            if (state_q == StExec) begin
                rsp_s_q <= ula_s;
            end
        end
    end

    // Output mapping.
    always_comb begin
        ula_a      = ula_a_q;
        ula_b      = ula_b_q;
        ula_x      = ula_op_q[OP_W-1];
        ula_y      = ula_op_q[1];
        ula_z      = ula_op_q[0];
        rsp_s      = rsp_s_q;
        rsp0_valid = (state_q == StResp) && !owner_q;
        rsp1_valid = (state_q == StResp) && owner_q;
        busy       = (state_q != StIdle);
`ifdef ULA_ARB_TIMEOUT_EN
        timeout    = timeout_q;
`endif
    end

endmodule
